// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl: operand registers, multicycle settle sequencer and HI/LO
// result pair placed downstream of the combinational signed Booth multiplier.
//
// Ports:
//   clock, clear         rising-edge clock, synchronous active-high reset
//   start, a_in, b_in    multiply request and signed operands (sampled in IDLE)
//   op_a, op_b           registered operands driven to the multiplier
//   product              64-bit signed product returned by the multiplier
//   hi_wr, lo_wr, bus_in direct HI/LO writes (move-to-HI/LO)
//   busy                 operation in flight (state != IDLE)
//   done                 one-cycle pulse in the cycle after the capture edge
//   hi, lo               result registers
//   ovf                  only with `define MULT_HILO_OVF_EN: last captured
//                        product did not fit in 32 signed bits
//
// Parameter MULT_CYCLES (1..15): edges from start-accept to capture.
module mult_hilo_ctrl #(
    parameter int MULT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [63:0] product,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic        hi_wr,
    input  logic        lo_wr,
    input  logic [31:0] bus_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
`ifdef MULT_HILO_OVF_EN
    output logic        ovf,
`endif
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MULT_CYCLES - 1);
    // A single-cycle multiplier skips the settle phase entirely.
    localparam state_t FIRST = (MULT_CYCLES == 1) ? CAPTURE : SETTLE;

    state_t     state;
    logic [3:0] cnt;

    assign busy = (state != IDLE);

`ifdef MULT_HILO_OVF_EN
    logic fits32;
    assign fits32 = (product[63:32] == {32{product[31]}});
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
            cnt   <= 4'd0;
            op_a  <= 32'd0;
            op_b  <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            done  <= 1'b0;
`ifdef MULT_HILO_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;

            // Capture owns HI/LO on its edge; direct writes are dropped there.
            if (state != CAPTURE) begin
                if (hi_wr) hi <= bus_in;
                if (lo_wr) lo <= bus_in;
`ifdef MULT_HILO_OVF_EN
                if (hi_wr || lo_wr) ovf <= 1'b0;
`endif
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a_in;
                        op_b  <= b_in;
                        cnt   <= CNT_INIT;
                        state <= FIRST;
                    end
                end
                SETTLE: begin
                    // Operands stay frozen so the adder tree sees a
                    // stable input for the whole multicycle window.
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) state <= CAPTURE;
                end
                CAPTURE: begin
                    hi    <= product[63:32];
                    lo    <= product[31:0];
                    done  <= 1'b1;
                    state <= IDLE;
`ifdef MULT_HILO_OVF_EN
                    ovf   <= ~fits32;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
